mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single-port behavioural memory between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
// - Round-robin arbitration, one access at a time.
// - Drives the memory MemReq/RdWrBar/Address/DataIn pins and captures DataOut after a programmable wait-state count.
// - Returns a one-cycle ack per access.
// PARAMETERS
// - DataWidth   32  memory/requester data width
// - AddrWidth   24  memory/requester address width
// - WaitStates  1   extra ACCESS cycles beyond the first (covers memory AccessTime); 0..2**CntWidth-1
// - CntWidth    4   wait-state counter width
// PORTS
// - clock        in   1          single clock; all state updates on posedge
// - reset        in   1          synchronous, active-high
// - p0_req       in   1          port 0 request; hold with p0_we/addr/wdata stable until p0_ack
// - p0_we        in   1          1=write, 0=read
// - p0_addr      in   AddrWidth  word address
// - p0_wdata     in   DataWidth  write data
// - p0_ack       out  1          one-cycle completion pulse
// - p0_rdata     out  DataWidth  read data, valid while p0_ack=1, held until next port-0 read completes
// - p1_req / p1_we / p1_addr / p1_wdata / p1_ack / p1_rdata   same as port 0
// - mem_req      out  1          to memory MemReq
// - mem_rdwrbar  out  1          to memory RdWrBar (1=read)
// - mem_addr     out  AddrWidth  to memory Address
// - mem_din      out  DataWidth  to memory DataIn
// - mem_dout     in   DataWidth  from memory DataOut
// BEHAVIOUR
// - Reset values: state=IDLE, mem_req=0, mem_rdwrbar=1, mem_addr=0, mem_din=0, p0/p1_ack=0, p0/p1_rdata=0, last_grant=1 (port 0 wins first tie).
// - All outputs are registered.
// - FSM states:
//   - IDLE: if any req is sampled at edge k -> ACCESS.
//     Winner: the sole requester; on a tie, the port not equal to last_grant.
//     At edge k: register winner addr/wdata/we into mem_*; mem_req=1; mem_rdwrbar=~we; cnt=0; last_grant=winner.
//   - ACCESS: mem_* held constant.
//     cnt<WaitStates: cnt++.
//     cnt==WaitStates: latch mem_dout into winner rdata (reads only); mem_req=0, mem_rdwrbar=1; winner ack=1 -> DONE.
//   - DONE: ack high for exactly this cycle -> IDLE; ack cleared.
// - Latency: req sampled at edge k -> ack high in the cycle after edge k+1+WaitStates.
// - Throughput: one access per WaitStates+3 cycles.
// - Writes: memory commits on the first ACCESS edge. Later ACCESS edges rewrite identical data, which is harmless.
// - Non-winning request stays pending, gets no ack, and is served next.
// - Under continuous contention, grants alternate strictly 0,1,0,1.
// - req dropped mid-access: the access still completes and ack still pulses. Requesters must not do this.
// - The other port's inputs changing mid-access have no effect; the granted address/data are latched.
// - A requester holding req through DONE is re-arbitrated in IDLE (back-to-back allowed; round-robin still applies).
// - Reset mid-ACCESS: returns to IDLE, no ack, rdata cleared. A write already committed at its first ACCESS edge stays in memory.
// - Address/data pass through unchanged. No width conversion; no out-of-range checking (memory wraps per its own decode).
// STRUCTURE
// - Package mem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), port index constants PORT_FETCH=1'b0 / PORT_DATA=1'b1.
// - Sub-module mem_rr_picker: combinational 2-way round-robin. Inputs req[1:0] and last_grant; outputs valid and grant.
// - FSM, wait counter and output registers live in mem_arbiter.
// TESTING (WaitStates=1 unless stated; bench connects the real memory model)
// - Reset: hold reset 3 cycles mid-traffic -> all outputs at reset values; no ack for 2 cycles after release.
// - Single read: preload word 0x010 = 0x1234_5678; p0 read 0x010 -> p0_ack exactly once, 3 cycles after req sampled; p0_rdata=0x1234_5678; p1_ack stays 0.
// - Write then read: p1 write 0x020 <= 0xDEAD_BEEF, then p1 read 0x020 -> 0xDEAD_BEEF; mem_rdwrbar=0 only during the write ACCESS.
// - Contention: p0 and p1 both requesting 8 reads continuously -> acks alternate 0,1,0,1,... starting with port 0; no lost or duplicate acks.
// - WaitStates=3: p0 read -> mem_req high exactly 4 cycles; ack 5 cycles after req sampled.
// - Reset mid-ACCESS: during a p1 read ACCESS, assert reset -> no p1_ack; next p1 read completes normally with correct data.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational two-way round-robin picker: the sole requester wins, and on a
// tie the port that was not granted last time wins.
module mem_rr_picker
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  // Pick winner from the current request vector and the previous grant
  always_comb begin
    valid = |req;
    grant = PORT_FETCH;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[PORT_DATA]) begin
      grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (port 0) and data
// (port 1). One access at a time, round-robin, registered memory pins,
// programmable wait states, one-cycle ack per completed access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 24,
  parameter int unsigned WaitStates = 1,
  parameter int unsigned CntWidth   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [AddrWidth-1:0] p0_addr,
  input  logic [DataWidth-1:0] p0_wdata,
  output logic                 p0_ack,
  output logic [DataWidth-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [AddrWidth-1:0] p1_addr,
  input  logic [DataWidth-1:0] p1_wdata,
  output logic                 p1_ack,
  output logic [DataWidth-1:0] p1_rdata,
  output logic                 mem_req,
  output logic                 mem_rdwrbar,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_din,
  input  logic [DataWidth-1:0] mem_dout
);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(WaitStates);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_rdwrbar_q, mem_rdwrbar_d;
  logic [AddrWidth-1:0]  mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0]  mem_din_q, mem_din_d;
  logic                  p0_ack_q, p0_ack_d;
  logic                  p1_ack_q, p1_ack_d;
  logic [DataWidth-1:0]  p0_rdata_q, p0_rdata_d;
  logic [DataWidth-1:0]  p1_rdata_q, p1_rdata_d;

  logic                  pick_valid;
  logic                  pick_grant;

  mem_rr_picker u_picker (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == CntLast) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; acks default low so they pulse one cycle
  always_comb begin
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    mem_req_d     = mem_req_q;
    mem_rdwrbar_d = mem_rdwrbar_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    p0_ack_d      = 1'b0;
    p1_ack_d      = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          last_grant_d = pick_grant;
          mem_req_d    = 1'b1;
          cnt_d        = '0;
          if (pick_grant == PORT_DATA) begin
            mem_addr_d    = p1_addr;
            mem_din_d     = p1_wdata;
            mem_rdwrbar_d = ~p1_we;
          end else begin
            mem_addr_d    = p0_addr;
            mem_din_d     = p0_wdata;
            mem_rdwrbar_d = ~p0_we;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q != CntLast) begin
          cnt_d = cnt_q + CntWidth'(1);
        end else begin
          // Winner is last_grant_q; its memory data is captured on reads only
          if (last_grant_q == PORT_DATA) begin
            p1_ack_d = 1'b1;
            if (mem_rdwrbar_q) p1_rdata_d = mem_dout;
          end else begin
            p0_ack_d = 1'b1;
            if (mem_rdwrbar_q) p0_rdata_d = mem_dout;
          end
          mem_req_d     = 1'b0;
          mem_rdwrbar_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      last_grant_q  <= PORT_DATA;
      mem_req_q     <= 1'b0;
      mem_rdwrbar_q <= 1'b1;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      mem_req_q     <= mem_req_d;
      mem_rdwrbar_q <= mem_rdwrbar_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      p0_ack_q      <= p0_ack_d;
      p1_ack_q      <= p1_ack_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_rdwrbar = mem_rdwrbar_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign p0_ack      = p0_ack_q;
  assign p1_ack      = p1_ack_q;
  assign p0_rdata    = p0_rdata_q;
  assign p1_rdata    = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (1 and 3 wait states) each with a
// small behavioural memory; per-port scoreboards checked on every ack.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 24;
  localparam int          TMO = 20;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // instance with one wait state
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack, p1_ack, mem_req, mem_rdwrbar;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  // instance with three wait states
  logic          p0_req_3 = 0, p0_we_3 = 0, p1_req_3 = 0, p1_we_3 = 0;
  logic [AW-1:0] p0_addr_3 = '0, p1_addr_3 = '0;
  logic [DW-1:0] p0_wdata_3 = '0, p1_wdata_3 = '0;
  logic          p0_ack_3, p1_ack_3, mem_req_3, mem_rdwrbar_3;
  logic [DW-1:0] p0_rdata_3, p1_rdata_3, mem_din_3, mem_dout_3;
  logic [AW-1:0] mem_addr_3;

  // backdoor preload
  logic          bd_we = 0, bd_sel = 0;
  logic [7:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [7:0]    idx1, idx3;

  int   total = 0, bad = 0;
  int   ack_cnt0 = 0, ack_cnt1 = 0, wr_low_total = 0, req3_total = 0, p1ack3_total = 0;
  exp_t q0[$], q1[$];
  logic ack_log[$];

  always #5 clock = ~clock;

  mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .WaitStates(1), .CntWidth(4)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_rdwrbar(mem_rdwrbar), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .WaitStates(3), .CntWidth(4)) dut3 (
    .clock(clock), .reset(reset),
    .p0_req(p0_req_3), .p0_we(p0_we_3), .p0_addr(p0_addr_3), .p0_wdata(p0_wdata_3),
    .p0_ack(p0_ack_3), .p0_rdata(p0_rdata_3),
    .p1_req(p1_req_3), .p1_we(p1_we_3), .p1_addr(p1_addr_3), .p1_wdata(p1_wdata_3),
    .p1_ack(p1_ack_3), .p1_rdata(p1_rdata_3),
    .mem_req(mem_req_3), .mem_rdwrbar(mem_rdwrbar_3), .mem_addr(mem_addr_3),
    .mem_din(mem_din_3), .mem_dout(mem_dout_3)
  );

  // Memories: address folded to 8 bits, combinational read, write on clock
  assign idx1 = mem_addr[7:0] ^ mem_addr[15:8] ^ mem_addr[23:16];
  assign idx3 = mem_addr_3[7:0] ^ mem_addr_3[15:8] ^ mem_addr_3[23:16];
  assign mem_dout   = mem1[idx1];
  assign mem_dout_3 = mem3[idx3];

  always_ff @(posedge clock) begin
    if (bd_we && !bd_sel) mem1[bd_addr] <= bd_data;
    else if (mem_req && !mem_rdwrbar) mem1[idx1] <= mem_din;
    if (bd_we && bd_sel) mem3[bd_addr] <= bd_data;
    else if (mem_req_3 && !mem_rdwrbar_3) mem3[idx3] <= mem_din_3;
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Monitor: pop and compare on every ack of the 1-wait-state instance
  always @(negedge clock) begin
    exp_t e;
    if (p0_ack) begin
      ack_cnt0++;
      ack_log.push_back(1'b0);
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack0: got ack with empty queue");
      end else begin
        e = q0.pop_front();
        if (!e.we) check("p0_rdata", p0_rdata, e.data);
      end
    end
    if (p1_ack) begin
      ack_cnt1++;
      ack_log.push_back(1'b1);
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack1: got ack with empty queue");
      end else begin
        e = q1.pop_front();
        if (!e.we) check("p1_rdata", p1_rdata, e.data);
      end
    end
    if (p0_ack && p1_ack) begin
      total++; bad++;
      $display("FAIL dual_ack: both acks high");
    end
    if (!mem_rdwrbar) begin
      wr_low_total++;
      check("rdwrbar_low_needs_req", 32'(mem_req), 32'd1);
    end
    if (mem_req_3) req3_total++;
    if (p1_ack_3) p1ack3_total++;
  end

  task automatic bd_write(input logic sel, input logic [7:0] a, input logic [DW-1:0] d);
    bd_sel = sel; bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  // Issue one access on the 1-wait-state instance and wait for its ack
  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data,
                           output int lat);
    exp_t e;
    e.we = we; e.data = exp_data;
    if (port) q1.push_back(e); else q0.push_back(e);
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
    lat = 0;
    forever begin
      @(posedge clock); #1;
      lat++;
      if (port ? p1_ack : p0_ack) break;
      if (lat >= TMO) begin
        total++; bad++;
        $display("FAIL timeout_port%0d: no ack after %0d cycles", port, lat);
        break;
      end
    end
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},     32'(mem_req),     32'd0);
    check({tag, "_mem_rdwrbar"}, 32'(mem_rdwrbar), 32'd1);
    check({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
    check({tag, "_mem_din"},     mem_din,          32'd0);
    check({tag, "_p0_ack"},      32'(p0_ack),      32'd0);
    check({tag, "_p1_ack"},      32'(p1_ack),      32'd0);
    check({tag, "_p0_rdata"},    p0_rdata,         32'd0);
    check({tag, "_p1_rdata"},    p1_rdata,         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, a1, w0, r0;
    // Reset and preload
    bd_write(1'b0, 8'h10, 32'h1234_5678);
    bd_write(1'b0, 8'h30, 32'h5555_AAAA);
    for (int i = 0; i < 16; i++) bd_write(1'b0, 8'(8'h80 + i), 32'hC0DE_0000 | 32'(8'h80 + i));
    bd_write(1'b1, 8'h40, 32'h0BAD_F00D);
    check_reset_outputs("init");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Single read on port 0
    a0 = ack_cnt0; a1 = ack_cnt1;
    do_access(1'b0, 1'b0, 24'h010, '0, 32'h1234_5678, lat);
    check("read_latency", 32'(lat), 32'd3);
    repeat (3) @(posedge clock);
    #1;
    check("read_ack0_count", 32'(ack_cnt0 - a0), 32'd1);
    check("read_ack1_count", 32'(ack_cnt1 - a1), 32'd0);

    // Write then read on port 1
    w0 = wr_low_total;
    do_access(1'b1, 1'b1, 24'h020, 32'hDEAD_BEEF, '0, lat);
    check("write_latency", 32'(lat), 32'd3);
    @(posedge clock); #1;
    check("write_rdwrbar_low_cycles", 32'(wr_low_total - w0), 32'd2);
    do_access(1'b1, 1'b0, 24'h020, '0, 32'hDEAD_BEEF, lat);
    check("wr_rd_latency", 32'(lat), 32'd3);
    @(posedge clock); #1;

    // Continuous contention: 8 reads on each port
    ack_log.delete();
    fork
      begin
        int l;
        for (int i = 0; i < 8; i++)
          do_access(1'b0, 1'b0, 24'(24'h080 + 2*i), '0, 32'hC0DE_0000 | 32'(8'h80 + 2*i), l);
      end
      begin
        int l;
        for (int i = 0; i < 8; i++)
          do_access(1'b1, 1'b0, 24'(24'h081 + 2*i), '0, 32'hC0DE_0000 | 32'(8'h81 + 2*i), l);
      end
    join
    repeat (3) @(posedge clock);
    #1;
    check("contention_ack_total", 32'(ack_log.size()), 32'd16);
    for (int i = 0; i < ack_log.size() && i < 16; i++)
      check($sformatf("contention_order_%0d", i), 32'(ack_log[i]), 32'(i % 2));

    // Reset in the middle of a port-1 read access
    a1 = ack_cnt1;
    p1_we = 1'b0; p1_addr = 24'h030; p1_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("abort_in_access", 32'(mem_req), 32'd1);
    reset = 1'b1; p1_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("midrst");
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check($sformatf("post_reset_noack_%0d", i), 32'({p1_ack, p0_ack}), 32'd0);
    end
    check("abort_no_p1_ack", 32'(ack_cnt1 - a1), 32'd0);
    do_access(1'b1, 1'b0, 24'h030, '0, 32'h5555_AAAA, lat);
    check("after_reset_latency", 32'(lat), 32'd3);
    @(posedge clock); #1;

    // Three wait states on the second instance
    r0 = req3_total;
    p0_we_3 = 1'b0; p0_addr_3 = 24'h040; p0_req_3 = 1'b1;
    lat = 0;
    forever begin
      @(posedge clock); #1;
      lat++;
      if (p0_ack_3) break;
      if (lat >= TMO) begin
        total++; bad++;
        $display("FAIL timeout_ws3: no ack after %0d cycles", lat);
        break;
      end
    end
    p0_req_3 = 1'b0;
    check("ws3_latency", 32'(lat), 32'd5);
    check("ws3_rdata", p0_rdata_3, 32'h0BAD_F00D);
    repeat (3) @(posedge clock);
    #1;
    check("ws3_mem_req_cycles", 32'(req3_total - r0), 32'd4);
    check("ws3_p1_ack_count", 32'(p1ack3_total), 32'd0);

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
